// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: upstream instruction/operands, writeback bypass,
// pipeline control and the registered EX-side outputs.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] rs1data;
  logic [XLEN-1:0] rs2data;
  logic            wb_wen;
  logic [4:0]      wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  logic            stall;
  logic            flush;
  logic            hazard_stall;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_rs1data;
  logic [XLEN-1:0] out_rs2data;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_instr, rs1data, rs2data,
           wb_wen, wb_waddr, wb_wdata, stall, flush,
    input  hazard_stall, out_valid, out_pc, out_instr, out_rs1data,
           out_rs2data, out_imm, out_rd, out_reg_write, out_mem_read,
           out_mem_write, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_instr, rs1data, rs2data,
           wb_wen, wb_waddr, wb_wdata, stall, flush,
    output hazard_stall, out_valid, out_pc, out_instr, out_rs1data,
           out_rs2data, out_imm, out_rd, out_reg_write, out_mem_read,
           out_mem_write, out_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// RV32I ID/EX pipeline register with decode, load-use hazard detection,
// stall/flush and optional same-cycle writeback bypass (macro WB_BYPASS_EN).
module id_ex_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:0] ins);
    logic signed [31:0] v;
    case (ins[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: v = {{20{ins[31]}}, ins[31:20]};
      OPC_STORE:  v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH: v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: v = {ins[31:12], 12'b0};
      OPC_JAL:    v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:    v = '0;
    endcase
    return XLEN'(v);
  endfunction

  logic [4:0]             w_rs1, w_rs2, w_rd;
  logic                   w_rs1_used, w_rs2_used, w_wr_op;
  logic                   w_mem_read, w_mem_write, w_illegal;
  logic                   w_hazard, w_bubble, w_load;
  logic [XLEN-1:0]        w_op1, w_op2;
  logic signed [XLEN-1:0] w_imm;

  logic                   r_valid_p1, r_reg_write_p1, r_mem_read_p1;
  logic                   r_mem_write_p1, r_illegal_p1;
  logic [XLEN-1:0]        r_pc_p1, r_rs1data_p1, r_rs2data_p1;
  logic signed [XLEN-1:0] r_imm_p1;
  logic [31:0]            r_instr_p1;
  logic [4:0]             r_rd_p1;

  assign w_rs1 = bus.in_instr[19:15];
  assign w_rs2 = bus.in_instr[24:20];
  assign w_rd  = bus.in_instr[11:7];
  assign w_imm = decode_imm(bus.in_instr);

  always_comb begin
    w_rs1_used  = 1'b1;
    w_rs2_used  = 1'b0;
    w_wr_op     = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_illegal   = 1'b0;
    case (bus.in_instr[6:0])
      OPC_LOAD:  begin w_wr_op = 1'b1; w_mem_read = 1'b1; end
      OPC_OPIMM, OPC_JALR: w_wr_op = 1'b1;
      OPC_OP:    begin w_wr_op = 1'b1; w_rs2_used = 1'b1; end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin w_wr_op = 1'b1; w_rs1_used = 1'b0; end
      OPC_STORE: begin w_mem_write = 1'b1; w_rs2_used = 1'b1; end
      OPC_BRANCH: w_rs2_used = 1'b1;
      default:   w_illegal = 1'b1;
    endcase
  end

  // Load-use: a LOAD sitting in EX whose rd feeds the instruction being decoded.
  assign w_hazard = r_valid_p1 & r_mem_read_p1 & (r_rd_p1 != 5'd0) & bus.in_valid &
                    ((w_rs1_used & (w_rs1 == r_rd_p1)) | (w_rs2_used & (w_rs2 == r_rd_p1)));
  assign bus.hazard_stall = w_hazard;

  assign w_bubble = bus.flush | (~bus.stall & (w_hazard | ~bus.in_valid));
  assign w_load   = ~bus.flush & ~bus.stall & ~w_hazard & bus.in_valid;

`ifdef WB_BYPASS_EN
  // Register file writes and reads in the same cycle; forward the write data.
  assign w_op1 = (bus.wb_wen && (bus.wb_waddr != 5'd0) && (bus.wb_waddr == w_rs1))
                 ? bus.wb_wdata : bus.rs1data;
  assign w_op2 = (bus.wb_wen && (bus.wb_waddr != 5'd0) && (bus.wb_waddr == w_rs2))
                 ? bus.wb_wdata : bus.rs2data;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{bus.wb_wen, bus.wb_waddr, bus.wb_wdata};
  assign w_op1 = bus.rs1data;
  assign w_op2 = bus.rs2data;
`endif

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      r_valid_p1     <= 1'b0;
      r_pc_p1        <= '0;
      r_instr_p1     <= NOP_INSTR;
      r_rs1data_p1   <= '0;
      r_rs2data_p1   <= '0;
      r_imm_p1       <= '0;
      r_rd_p1        <= '0;
      r_reg_write_p1 <= 1'b0;
      r_mem_read_p1  <= 1'b0;
      r_mem_write_p1 <= 1'b0;
      r_illegal_p1   <= 1'b0;
    end else if (w_load) begin
      r_valid_p1     <= 1'b1;
      r_pc_p1        <= bus.in_pc;
      r_instr_p1     <= bus.in_instr;
      r_rs1data_p1   <= w_op1;
      r_rs2data_p1   <= w_op2;
      r_imm_p1       <= w_imm;
      r_rd_p1        <= w_rd;
      r_reg_write_p1 <= w_wr_op & (w_rd != 5'd0);
      r_mem_read_p1  <= w_mem_read;
      r_mem_write_p1 <= w_mem_write;
      r_illegal_p1   <= w_illegal;
    end
  end

  assign bus.out_valid     = r_valid_p1;
  assign bus.out_pc        = r_pc_p1;
  assign bus.out_instr     = r_instr_p1;
  assign bus.out_rs1data   = r_rs1data_p1;
  assign bus.out_rs2data   = r_rs2data_p1;
  assign bus.out_imm       = r_imm_p1;
  assign bus.out_rd        = r_rd_p1;
  assign bus.out_reg_write = r_reg_write_p1;
  assign bus.out_mem_read  = r_mem_read_p1;
  assign bus.out_mem_write = r_mem_write_p1;
  assign bus.out_illegal   = r_illegal_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expectations queued at drive time and
// compared one clock later; hazard_stall checked combinationally.
module tb_id_ex_stage;
  localparam logic [31:0] NOP = 32'h00000013;
`ifdef WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h0000DEAD;
`else
  localparam logic [31:0] BYP_EXP = 32'h0;
`endif
  localparam logic [31:0] I_ADDI = 32'hFFC08293;  // addi x5,x1,-4
  localparam logic [31:0] I_LW   = 32'h00012303;  // lw x6,0(x2)
  localparam logic [31:0] I_ADD  = 32'h003303B3;  // add x7,x6,x3
  localparam logic [31:0] I_SW   = 32'h00312423;  // sw x3,8(x2)

  typedef struct {
    logic        v;
    logic [31:0] pc, instr, r1, r2, imm;
    logic [4:0]  rd;
    logic        rw, mr, mw, il;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32)) u_if ();
  id_ex_stage #(.XLEN(32), .NOP_INSTR(NOP)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic exp_t bub();
    exp_t e;
    e.v = 1'b0; e.pc = '0; e.instr = NOP; e.r1 = '0; e.r2 = '0; e.imm = '0;
    e.rd = '0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.il = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, ins, r1, r2, imm,
                              input logic [4:0] rd, input logic rw, mr, mw, il);
    exp_t e;
    e.v = 1'b1; e.pc = pc; e.instr = ins; e.r1 = r1; e.r2 = r2; e.imm = imm;
    e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw; e.il = il;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(u_if.out_valid), 32'(e.v));
    chk({tag, ".pc"}, u_if.out_pc, e.pc);
    chk({tag, ".instr"}, u_if.out_instr, e.instr);
    chk({tag, ".rs1data"}, u_if.out_rs1data, e.r1);
    chk({tag, ".rs2data"}, u_if.out_rs2data, e.r2);
    chk({tag, ".imm"}, u_if.out_imm, e.imm);
    chk({tag, ".rd"}, 32'(u_if.out_rd), 32'(e.rd));
    chk({tag, ".reg_write"}, 32'(u_if.out_reg_write), 32'(e.rw));
    chk({tag, ".mem_read"}, 32'(u_if.out_mem_read), 32'(e.mr));
    chk({tag, ".mem_write"}, 32'(u_if.out_mem_write), 32'(e.mw));
    chk({tag, ".illegal"}, 32'(u_if.out_illegal), 32'(e.il));
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    chk({tag, ".pending"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp(tag, e);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, ins, r1, r2);
    u_if.in_valid = v;
    u_if.in_pc    = pc;
    u_if.in_instr = ins;
    u_if.rs1data  = r1;
    u_if.rs2data  = r2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded budget", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    u_if.wb_wen = 1'b0; u_if.wb_waddr = '0; u_if.wb_wdata = '0;
    u_if.stall = 1'b0; u_if.flush = 1'b0;
    #2 rst_n = 1'b0;
    #1 cmp("reset", bub());
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    drive(1'b1, 32'h100, I_ADDI, 32'd7, 32'h22);
    #1 chk("hz_addi", 32'(u_if.hazard_stall), 32'd0);
    sb.push_back(mk(32'h100, I_ADDI, 32'd7, 32'h22, 32'hFFFFFFFC, 5'd5, 1, 0, 0, 0));
    step("addi");

    drive(1'b1, 32'h104, I_LW, 32'h1000, 32'h5);
    sb.push_back(mk(32'h104, I_LW, 32'h1000, 32'h5, 32'h0, 5'd6, 1, 1, 0, 0));
    step("lw");
    drive(1'b1, 32'h108, I_ADD, 32'h11, 32'h33);
    #1 chk("hz_set", 32'(u_if.hazard_stall), 32'd1);
    sb.push_back(bub());
    step("hz_bubble");
    chk("hz_clear", 32'(u_if.hazard_stall), 32'd0);
    sb.push_back(mk(32'h108, I_ADD, 32'h11, 32'h33, 32'h0, 5'd7, 1, 0, 0, 0));
    step("add");

    drive(1'b1, 32'h10C, I_LW, 32'h2000, 32'h6);
    sb.push_back(mk(32'h10C, I_LW, 32'h2000, 32'h6, 32'h0, 5'd6, 1, 1, 0, 0));
    step("lw2");
    drive(1'b1, 32'h110, I_ADD, 32'h44, 32'h55);
    u_if.flush = 1'b1;
    #1 chk("hz_flush", 32'(u_if.hazard_stall), 32'd1);
    sb.push_back(bub());
    step("flush_lw");
    u_if.flush = 1'b0;
    chk("hz_after_flush", 32'(u_if.hazard_stall), 32'd0);
    sb.push_back(mk(32'h110, I_ADD, 32'h44, 32'h55, 32'h0, 5'd7, 1, 0, 0, 0));
    step("add2");

    drive(1'b1, 32'h200, I_SW, 32'h1000, 32'hABCD);
    sb.push_back(mk(32'h200, I_SW, 32'h1000, 32'hABCD, 32'd8, 5'd8, 0, 0, 1, 0));
    step("sw");
    u_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, $urandom, $urandom);
      sb.push_back(mk(32'h200, I_SW, 32'h1000, 32'hABCD, 32'd8, 5'd8, 0, 0, 1, 0));
      step("stall_hold");
    end
    u_if.flush = 1'b1;
    sb.push_back(bub());
    step("flush_stall");
    u_if.flush = 1'b0;
    u_if.stall = 1'b0;

    drive(1'b0, 32'h300, I_ADDI, 32'd1, 32'd2);
    sb.push_back(bub());
    step("invalid");

    drive(1'b1, 32'h304, 32'hFE208EE3, 32'd3, 32'd4);
    sb.push_back(mk(32'h304, 32'hFE208EE3, 32'd3, 32'd4, 32'hFFFFFFFC, 5'd29, 0, 0, 0, 0));
    step("beq");
    drive(1'b1, 32'h308, 32'h0000007F, 32'd5, 32'd6);
    sb.push_back(mk(32'h308, 32'h0000007F, 32'd5, 32'd6, 32'h0, 5'd0, 0, 0, 0, 1));
    step("illegal");
    drive(1'b1, 32'h30C, 32'h12345537, 32'd7, 32'd8);
    sb.push_back(mk(32'h30C, 32'h12345537, 32'd7, 32'd8, 32'h12345000, 5'd10, 1, 0, 0, 0));
    step("lui");
    drive(1'b1, 32'h310, 32'hFF9FF0EF, 32'd9, 32'd10);
    sb.push_back(mk(32'h310, 32'hFF9FF0EF, 32'd9, 32'd10, 32'hFFFFFFF8, 5'd1, 1, 0, 0, 0));
    step("jal_neg");
    drive(1'b1, 32'h314, 32'h0000006F, 32'd11, 32'd12);
    sb.push_back(mk(32'h314, 32'h0000006F, 32'd11, 32'd12, 32'h0, 5'd0, 0, 0, 0, 0));
    step("jal_x0");

    u_if.wb_wen = 1'b1; u_if.wb_waddr = 5'd1; u_if.wb_wdata = 32'hDEAD;
    drive(1'b1, 32'h400, I_ADDI, 32'h0, 32'h9);
    sb.push_back(mk(32'h400, I_ADDI, BYP_EXP, 32'h9, 32'hFFFFFFFC, 5'd5, 1, 0, 0, 0));
    step("byp_hit");
    u_if.wb_waddr = 5'd0;
    drive(1'b1, 32'h404, I_ADDI, 32'h0, 32'h9);
    sb.push_back(mk(32'h404, I_ADDI, 32'h0, 32'h9, 32'hFFFFFFFC, 5'd5, 1, 0, 0, 0));
    step("byp_x0");
    u_if.wb_wen = 1'b0;

    drive(1'b1, 32'h500, I_ADDI, 32'd7, 32'h22);
    sb.push_back(mk(32'h500, I_ADDI, 32'd7, 32'h22, 32'hFFFFFFFC, 5'd5, 1, 0, 0, 0));
    step("pre_rst");
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #3 rst_n = 1'b0;
    #1 cmp("async_rst", bub());
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cmp("post_rst", bub());

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
